// File: rtl/mcb_port_arbiter_pkg.sv
// Shared encodings for the MCB command-port arbiter: command opcodes, FSM states, default widths.
package mcb_port_arbiter_pkg;

   localparam int ADDR_W_DEF     = 30;
   localparam int BL_W_DEF       = 6;
   localparam int STARVE_MAX_DEF = 16;

   localparam logic [2:0] MCB_CMD_READ  = 3'b001;
   localparam logic [2:0] MCB_CMD_WRITE = 3'b000;

   typedef enum logic [1:0] {
      ST_WAIT_CAL = 2'd0,
      ST_IDLE     = 2'd1,
      ST_ISSUE    = 2'd2,
      ST_GAP      = 2'd3
   } arb_state_t;

endpackage

// File: rtl/mcb_port_arbiter_synchro.sv
// Two-flop synchroniser for a single asynchronous level; 2-cycle latency, no backpressure.
module mcb_port_arbiter_synchro (
   input  logic clk,
   input  logic reset_n,
   input  logic d,
   output logic q
);

   logic meta;

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         meta <= 1'b0;
         q    <= 1'b0;
      end else begin
         meta <= d;
         q    <= meta;
      end
   end

endmodule

// File: rtl/mcb_port_arbiter.sv
// Arbitrates read/write requesters onto one MCB command port; strobe one cycle after an IDLE pick,
// commands at least 3 cycles apart, holds off on cmd_full / lost calibration / short write data.
module mcb_port_arbiter
   import mcb_port_arbiter_pkg::*;
#(
   parameter int ADDR_W     = ADDR_W_DEF,
   parameter int BL_W       = BL_W_DEF,
   parameter int STARVE_MAX = STARVE_MAX_DEF
) (
   input  logic              clk,
   input  logic              reset_n,
   input  logic              mem_calib_done,
   input  logic              rd_req,
   input  logic [ADDR_W-1:0] rd_addr,
   input  logic [BL_W-1:0]   rd_bl,
   output logic              rd_gnt,
   input  logic              wr_req,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [BL_W-1:0]   wr_bl,
   output logic              wr_gnt,
   input  logic [6:0]        wr_fifo_count,
   input  logic              cmd_full,
   output logic              cmd_en,
   output logic [2:0]        cmd_instr,
   output logic [BL_W-1:0]   cmd_bl,
   output logic [ADDR_W-1:0] cmd_byte_addr,
   output logic              calibrated
);

   localparam int SC_W = $clog2(STARVE_MAX + 1);

   arb_state_t        state, state_nxt;
   logic [SC_W-1:0]   starve_cnt;
   logic [6:0]        wr_need;
   logic              wr_ok, starve_hit;
   logic              pick_rd, pick_wr, issue;
   logic [ADDR_W-1:0] sel_addr;

   mcb_port_arbiter_synchro u_cal_sync (
      .clk     (clk),
      .reset_n (reset_n),
      .d       (mem_calib_done),
      .q       (calibrated)
   );

   // A write is only eligible once its whole burst is already in the data FIFO.
   assign wr_need    = 7'(wr_bl) + 7'd1;
   assign wr_ok      = wr_req && (wr_fifo_count >= wr_need);
   assign starve_hit = (starve_cnt == SC_W'(STARVE_MAX));
   assign issue      = pick_rd | pick_wr;
   assign sel_addr   = pick_rd ? rd_addr : wr_addr;

   always_comb begin
      state_nxt = state;
      pick_rd   = 1'b0;
      pick_wr   = 1'b0;
      case (state)
         ST_WAIT_CAL: begin
            if (calibrated) state_nxt = ST_IDLE;
         end
         ST_IDLE: begin
            if (!calibrated) begin
               state_nxt = ST_WAIT_CAL;
            end else if (!cmd_full) begin
               // Reads win ties for the display deadline unless writes have starved long enough.
               if (wr_ok && (!rd_req || starve_hit)) pick_wr = 1'b1;
               else if (rd_req)                      pick_rd = 1'b1;
               if (pick_rd || pick_wr) state_nxt = ST_ISSUE;
            end
         end
         ST_ISSUE: state_nxt = calibrated ? ST_GAP  : ST_WAIT_CAL;
         ST_GAP:   state_nxt = calibrated ? ST_IDLE : ST_WAIT_CAL;
         default:  state_nxt = ST_WAIT_CAL;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state <= ST_WAIT_CAL;
      else          state <= state_nxt;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         cmd_en        <= 1'b0;
         rd_gnt        <= 1'b0;
         wr_gnt        <= 1'b0;
         cmd_instr     <= 3'b000;
         cmd_bl        <= '0;
         cmd_byte_addr <= '0;
      end else begin
         cmd_en <= issue;
         rd_gnt <= pick_rd;
         wr_gnt <= pick_wr;
         if (issue) begin
            cmd_instr     <= pick_rd ? MCB_CMD_READ : MCB_CMD_WRITE;
            cmd_bl        <= pick_rd ? rd_bl : wr_bl;
            cmd_byte_addr <= {sel_addr[ADDR_W-1:2], 2'b00};
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         starve_cnt <= '0;
      end else if (!calibrated || !wr_req || pick_wr) begin
         starve_cnt <= '0;
      end else if (pick_rd && !starve_hit) begin
         starve_cnt <= starve_cnt + SC_W'(1);
      end
   end

endmodule

// File: tb/tb_mcb_port_arbiter.sv
// Directed and randomized checks of mcb_port_arbiter against a cycle-level behavioural model.
module tb_mcb_port_arbiter;

   localparam int SMAX = 16;

   logic        clk = 1'b0;
   logic        reset_n, mem_calib_done, rd_req, wr_req, cmd_full;
   logic [29:0] rd_addr, wr_addr, cmd_byte_addr;
   logic [5:0]  rd_bl, wr_bl, cmd_bl;
   logic [6:0]  wr_fifo_count;
   logic        rd_gnt, wr_gnt, cmd_en, calibrated;
   logic [2:0]  cmd_instr;

   mcb_port_arbiter dut (
      .clk            (clk),
      .reset_n        (reset_n),
      .mem_calib_done (mem_calib_done),
      .rd_req         (rd_req),
      .rd_addr        (rd_addr),
      .rd_bl          (rd_bl),
      .rd_gnt         (rd_gnt),
      .wr_req         (wr_req),
      .wr_addr        (wr_addr),
      .wr_bl          (wr_bl),
      .wr_gnt         (wr_gnt),
      .wr_fifo_count  (wr_fifo_count),
      .cmd_full       (cmd_full),
      .cmd_en         (cmd_en),
      .cmd_instr      (cmd_instr),
      .cmd_bl         (cmd_bl),
      .cmd_byte_addr  (cmd_byte_addr),
      .calibrated     (calibrated)
   );

   always #5 clk = ~clk;

   int errors = 0;
   int checks = 0;
   int cyc = 0;
   int last_en = -100;

   // Model: calibration delay line, "online" flag, cooldown cycles after a strobe, starvation tally.
   bit          m_s1, m_cal, m_online;
   int          m_cool, m_starve;
   logic        m_en, m_rg, m_wg;
   logic [2:0]  m_instr;
   logic [5:0]  m_bl;
   logic [29:0] m_addr;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic model_reset();
      m_s1 = 0; m_cal = 0; m_online = 0; m_cool = 0; m_starve = 0;
      m_en = 0; m_rg = 0; m_wg = 0; m_instr = 3'd0; m_bl = 6'd0; m_addr = 30'd0;
   endtask

   task automatic model_edge();
      bit wr_ok, take_rd, take_wr;
      wr_ok   = wr_req && (int'(wr_fifo_count) >= int'(wr_bl) + 1);
      take_rd = 0;
      take_wr = 0;
      m_en = 0; m_rg = 0; m_wg = 0;
      if (!m_cal) begin
         m_online = 0;
         m_cool   = 0;
      end else if (!m_online) begin
         m_online = 1;
      end else if (m_cool > 0) begin
         m_cool--;
      end else if (!cmd_full) begin
         if (wr_ok && (!rd_req || m_starve == SMAX)) take_wr = 1;
         else if (rd_req)                           take_rd = 1;
         else if (wr_ok)                            take_wr = 1;
      end
      if (take_rd || take_wr) begin
         m_en    = 1;
         m_rg    = take_rd;
         m_wg    = take_wr;
         m_cool  = 2;
         m_instr = take_rd ? 3'b001 : 3'b000;
         m_bl    = take_rd ? rd_bl : wr_bl;
         m_addr  = (take_rd ? rd_addr : wr_addr) & ~30'd3;
      end
      if (!m_cal || !wr_req || take_wr) m_starve = 0;
      else if (take_rd && m_starve < SMAX) m_starve++;
      m_cal = m_s1;
      m_s1  = mem_calib_done;
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
      cyc++;
      chk("cmd_en", 32'(cmd_en), 32'(m_en));
      chk("rd_gnt", 32'(rd_gnt), 32'(m_rg));
      chk("wr_gnt", 32'(wr_gnt), 32'(m_wg));
      chk("calibrated", 32'(calibrated), 32'(m_cal));
      chk("cmd_instr", 32'(cmd_instr), 32'(m_instr));
      chk("cmd_bl", 32'(cmd_bl), 32'(m_bl));
      chk("cmd_byte_addr", 32'(cmd_byte_addr), 32'(m_addr));
      if (cmd_en === 1'b1) begin
         chk("cmd_spacing_ge3", 32'((cyc - last_en) >= 3), 32'd1);
         last_en = cyc;
      end
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   initial begin
      int  lat, n_en, reads_before, reads_after, grants;
      bit  found, seen_wr;

      reset_n = 0; mem_calib_done = 0; rd_req = 0; wr_req = 0; cmd_full = 0;
      rd_addr = 30'd0; wr_addr = 30'd0; rd_bl = 6'd0; wr_bl = 6'd0; wr_fifo_count = 7'd0;
      model_reset();
      @(posedge clk);
      @(posedge clk);
      #1;
      chk("rst_cmd_en", 32'(cmd_en), 32'd0);
      chk("rst_gnts", 32'({rd_gnt, wr_gnt}), 32'd0);
      chk("rst_calibrated", 32'(calibrated), 32'd0);
      chk("rst_cmd_fields", 32'(cmd_instr) | 32'(cmd_bl) | 32'(cmd_byte_addr), 32'd0);
      @(negedge clk);
      reset_n = 1;

      // 1/2: no traffic before calibration, then first read after sync + WAIT_CAL exit.
      rd_req = 1; rd_addr = 30'h0050_0003; rd_bl = 6'd63;
      n_en = 0;
      repeat (8) begin
         tick();
         if (cmd_en === 1'b1) n_en++;
      end
      chk("no_cmd_uncalibrated", 32'(n_en), 32'd0);
      mem_calib_done = 1;
      found = 0; lat = 0;
      for (int i = 1; i <= 10 && !found; i++) begin
         tick();
         if (cmd_en === 1'b1) begin found = 1; lat = i; end
      end
      chk("calib_to_cmd_cycles", 32'(lat), 32'd4);
      chk("first_rd_gnt", 32'(rd_gnt), 32'd1);
      chk("first_instr_read", 32'(cmd_instr), 32'b001);
      chk("first_addr_aligned", 32'(cmd_byte_addr), 32'h0050_0000);
      chk("first_bl", 32'(cmd_bl), 32'd63);
      rd_req = 0;
      tick();
      chk("strobe_single_cycle", 32'({cmd_en, rd_gnt}), 32'd0);

      // 3: write held off until the FIFO holds the full burst.
      wr_req = 1; wr_bl = 6'd31; wr_fifo_count = 7'd31; wr_addr = 30'h0012_3457;
      seen_wr = 0;
      repeat (10) begin
         tick();
         if (wr_gnt === 1'b1) seen_wr = 1;
      end
      chk("wr_blocked_short_data", 32'(seen_wr), 32'd0);
      wr_fifo_count = 7'd32;
      found = 0;
      for (int i = 0; i < 6 && !found; i++) begin
         tick();
         if (wr_gnt === 1'b1) found = 1;
      end
      chk("wr_granted_full_data", 32'(found), 32'd1);
      chk("wr_instr", 32'(cmd_instr), 32'b000);
      chk("wr_addr_aligned", 32'(cmd_byte_addr), 32'h0012_3454);
      wr_req = 0;
      repeat (3) tick();

      // 4: starvation bound, twice, proving the counter restarts after the write.
      rd_req = 1; rd_bl = 6'd3; rd_addr = 30'h0000_1000;
      wr_req = 1; wr_bl = 6'd7; wr_addr = 30'h0000_2000; wr_fifo_count = 7'd64;
      reads_before = 0; reads_after = 0; grants = 0;
      for (int i = 0; i < 300 && grants < 2; i++) begin
         tick();
         if (rd_gnt === 1'b1) begin
            if (grants == 0) reads_before++;
            else reads_after++;
         end
         if (wr_gnt === 1'b1) grants++;
      end
      chk("reads_before_write", 32'(reads_before), 32'd16);
      chk("reads_after_write", 32'(reads_after), 32'd16);
      chk("writes_seen", 32'(grants), 32'd2);

      // 5: cmd_full holds everything off; release issues the read at once.
      cmd_full = 1;
      n_en = 0;
      repeat (20) begin
         tick();
         if (cmd_en === 1'b1) n_en++;
      end
      chk("no_cmd_while_full", 32'(n_en), 32'd0);
      cmd_full = 0;
      tick();
      chk("release_cmd_en", 32'(cmd_en), 32'd1);
      chk("release_rd_gnt", 32'(rd_gnt), 32'd1);

      // 6: asynchronous reset while a strobe is on the port.
      reset_n = 0;
      #1;
      chk("arst_cmd_en", 32'(cmd_en), 32'd0);
      chk("arst_gnts", 32'({rd_gnt, wr_gnt}), 32'd0);
      chk("arst_calibrated", 32'(calibrated), 32'd0);
      chk("arst_fields", 32'(cmd_instr) | 32'(cmd_bl) | 32'(cmd_byte_addr), 32'd0);
      model_reset();
      @(negedge clk);
      reset_n = 1;
      wr_req = 0;
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         tick();
         if (cmd_en === 1'b1) found = 1;
      end
      chk("recover_after_reset", 32'(found), 32'd1);
      rd_req = 0;
      repeat (4) tick();
      mem_calib_done = 0;
      repeat (3) tick();
      chk("calib_dropped", 32'(calibrated), 32'd0);
      rd_req = 1;
      n_en = 0;
      repeat (15) begin
         tick();
         if (cmd_en === 1'b1) n_en++;
      end
      chk("no_cmd_after_calib_loss", 32'(n_en), 32'd0);
      mem_calib_done = 1;
      found = 0;
      for (int i = 0; i < 10 && !found; i++) begin
         tick();
         if (cmd_en === 1'b1) found = 1;
      end
      chk("cmd_after_recal", 32'(found), 32'd1);

      // Randomized traffic; requesters hold their fields until granted or dropped.
      for (int i = 0; i < 3000; i++) begin
         if (rd_gnt === 1'b1 || !rd_req) begin
            rd_req  = ($urandom_range(0, 2) != 0);
            rd_addr = 30'($urandom);
            rd_bl   = 6'($urandom);
         end else if ($urandom_range(0, 15) == 0) begin
            rd_req = 0;
         end
         if (wr_gnt === 1'b1 || !wr_req) begin
            wr_req  = ($urandom_range(0, 1) != 0);
            wr_addr = 30'($urandom);
            wr_bl   = 6'($urandom_range(0, 31));
         end else if ($urandom_range(0, 15) == 0) begin
            wr_req = 0;
         end
         wr_fifo_count = 7'($urandom_range(0, 64));
         cmd_full      = ($urandom_range(0, 4) == 0);
         if (mem_calib_done && $urandom_range(0, 299) == 0) mem_calib_done = 0;
         else if (!mem_calib_done && $urandom_range(0, 9) == 0) mem_calib_done = 1;
         tick();
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
